// File: rtl/mem_op_pkg.sv
// Shared types and default widths for the memory operation sequencer.
package mem_op_pkg;

  localparam int unsigned DEF_DW = 8;
  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_CW = 8;

  typedef enum logic [1:0] {
    OP_XOR = 2'd0,
    OP_AND = 2'd1,
    OP_OR  = 2'd2,
    OP_ADD = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/mem_op_alu.sv
// Combinational ALU: XOR / AND / OR / ADD (wrapping, no carry out).
module mem_op_alu
  import mem_op_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  op_e           op,
  output logic [DW-1:0] y
);

  // Select the result of the requested operation.
  always_comb begin
    y = '0;
    case (op)
      OP_XOR:  y = a ^ b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  y = a + b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mem_op_engine.sv
// Data-memory operation sequencer: for each element pair reads A and B,
// applies the latched op and writes the result, three cycles per element.
module mem_op_engine
  import mem_op_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned CW = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op_sel,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  input  logic [AW-1:0] dst,
  input  logic [CW-1:0] count,
  output logic [AW-1:0] dm_addr,
  output logic          dm_wr_en,
  output logic [DW-1:0] dm_dat_in,
  input  logic [DW-1:0] dm_dat_out,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  state_e        state;
  op_e           op_q;
  logic [AW-1:0] src_a_q;
  logic [AW-1:0] src_b_q;
  logic [AW-1:0] dst_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] idx;
  logic [CW-1:0] idx_inc;
  logic [AW-1:0] idx_aw;
  logic [AW-1:0] inc_aw;
  logic [DW-1:0] opa;
  logic [DW-1:0] alu_y;

  assign idx_inc = idx + CW'(1);
  assign idx_aw  = AW'(idx);
  assign inc_aw  = AW'(idx_inc);

  // Operand B is taken straight from the read port during RD_B; the result
  // is registered into dm_dat_in so it is stable for the whole WR cycle.
  mem_op_alu #(.DW(DW)) u_alu (
    .a  (opa),
    .b  (dm_dat_out),
    .op (op_q),
    .y  (alu_y)
  );

  // Busy covers exactly the three memory-access states.
  always_comb begin
    busy = (state == RD_A) || (state == RD_B) || (state == WR);
  end

  // Sequencer FSM; memory-side outputs are set for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_XOR;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      count_q   <= '0;
      idx       <= '0;
      opa       <= '0;
      dm_addr   <= '0;
      dm_wr_en  <= 1'b0;
      dm_dat_in <= '0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q     <= op_e'(op_sel);
            src_a_q  <= src_a;
            src_b_q  <= src_b;
            dst_q    <= dst;
            count_q  <= count;
            idx      <= '0;
            checksum <= '0;
            done     <= 1'b0;
            if (count != '0) begin
              state   <= RD_A;
              dm_addr <= src_a;
            end else begin
              state   <= DONE;
            end
          end else if (state == DONE) begin
            done <= 1'b1;
          end
        end
        RD_A: begin
          opa     <= dm_dat_out;
          dm_addr <= src_b_q + idx_aw;
          state   <= RD_B;
        end
        RD_B: begin
          dm_addr   <= dst_q + idx_aw;
          dm_wr_en  <= 1'b1;
          dm_dat_in <= alu_y;
          state     <= WR;
        end
        WR: begin
          dm_wr_en <= 1'b0;
          checksum <= checksum ^ dm_dat_in;
          idx      <= idx_inc;
          if (idx_inc == count_q) begin
            state   <= DONE;
            done    <= 1'b1;
            dm_addr <= '0;
          end else begin
            state   <= RD_A;
            dm_addr <= src_a_q + inc_aw;
          end
        end
        default: begin
          state    <= IDLE;
          dm_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
